// File: rtl/lsu_pkg.sv
// lsu_pkg: shared types, funct3 codes and lane helpers for the load/store unit.
package lsu_pkg;
  localparam logic [2:0] FNC_LB = 3'b000, FNC_LH = 3'b001, FNC_LW = 3'b010;
  localparam logic [2:0] FNC_LBU = 3'b100, FNC_LHU = 3'b101;
  localparam logic [2:0] FNC_SB = 3'b000, FNC_SH = 3'b001, FNC_SW = 3'b010;
  localparam int WADDR_W = 30;
  typedef struct packed {
    logic [WADDR_W-1:0] waddr;
    logic [3:0] mask;
    logic [31:0] data;
  } sb_entry_t;
  typedef struct packed {
    logic [3:0] mask;
    logic [31:0] data;
  } lanes_t;
  typedef enum logic {IDLE, LOAD_WAIT} lsu_state_t;
  function automatic lanes_t store_lanes(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] wd);
    lanes_t r;
    r.mask = f3[1:0] == FNC_SB[1:0] ? 4'b0001 << off :
             f3[1:0] == FNC_SH[1:0] ? 4'b0011 << off :
             f3[1:0] == FNC_SW[1:0] ? 4'b1111 : 4'b0000;
    r.data = wd << {off, 3'b000};
    return r;
  endfunction
  function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [1:0] off, input logic [31:0] w);
    logic [31:0] s;
    s = w >> {off, 3'b000};
    return f3 == FNC_LB  ? {{24{s[7]}}, s[7:0]} :
           f3 == FNC_LBU ? {24'd0, s[7:0]} :
           f3 == FNC_LH  ? {{16{s[15]}}, s[15:0]} :
           f3 == FNC_LHU ? {16'd0, s[15:0]} :
           f3 == FNC_LW  ? w : s;
  endfunction
endpackage

// File: rtl/lsu_sb_fifo.sv
// lsu_sb_fifo: in-order store buffer with a parallel word-address match port.
// LSU_FORWARD_EN adds the full-cover test and youngest-match data output.
module lsu_sb_fifo
  import lsu_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  sb_entry_t          din,
  input  logic [WADDR_W-1:0] match_waddr,
`ifdef LSU_FORWARD_EN
  input  logic [3:0]         match_mask,
  output logic               full_cover,
  output logic [31:0]        fwd_data,
`endif
  output logic               hit,
  output sb_entry_t          head_e,
  output logic               empty,
  output logic               full
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  sb_entry_t mem [DEPTH];
  logic [PW-1:0] head, tail;
  logic [CW-1:0] count;
  always_ff @(posedge clk) begin
    if (reset) begin
      head <= '0;
      tail <= '0;
      count <= '0;
    end else begin
      if (push) tail <= tail + 1'b1;
      if (pop) head <= head + 1'b1;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge clk)
    if (push) mem[tail] <= din;
  assign head_e = mem[head];
  assign empty = count == '0;
  assign full = count == CW'(DEPTH);
  // Walk oldest to youngest so the last match seen is the youngest.
  always_comb begin
    hit = 1'b0;
`ifdef LSU_FORWARD_EN
    full_cover = 1'b0;
    fwd_data = '0;
`endif
    for (int k = 0; k < DEPTH; k++)
      if (CW'(k) < count && mem[head + PW'(k)].waddr == match_waddr) begin
        hit = 1'b1;
`ifdef LSU_FORWARD_EN
        full_cover = (mem[head + PW'(k)].mask & match_mask) == match_mask;
        fwd_data = mem[head + PW'(k)].data;
`endif
      end
  end
endmodule

// File: rtl/lsu_store_buffer_unit.sv
// lsu_store_buffer_unit: load/store unit with in-order store buffer and one cache port.
// Define LSU_FORWARD_EN to forward fully covered loads from the buffer.
module lsu_store_buffer_unit
  import lsu_pkg::*;
#(
  parameter int SB_DEPTH = 4,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mem_valid,
  input  logic              mem_store,
  input  logic [2:0]        funct3,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic              lsu_stall,
  output logic              load_valid,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic              sb_empty,
  output logic [ADDR_W-1:0] dcache_addr,
  output logic [3:0]        dcache_we,
  output logic              dcache_re,
  output logic [31:0]       dcache_din,
  input  logic [31:0]       dcache_dout,
  input  logic              dcache_busy
);
  lsu_state_t state, state_next;
  sb_entry_t new_e, head_e;
  lanes_t lanes;
  logic hit, empty, full, bad, act, is_ld, is_st, fwd, ld_issue, drain, pop, push;
  logic [31:0] ld_src;
`ifdef LSU_FORWARD_EN
  logic full_cover;
  logic [31:0] fwd_data;
`endif
  assign lanes = store_lanes(funct3, addr[1:0], wdata);
  assign new_e = '{waddr: WADDR_W'(addr[ADDR_W-1:2]), mask: lanes.mask, data: lanes.data};
  assign bad = (funct3[1:0] == FNC_SH[1:0] && addr[0]) || (funct3[1:0] == FNC_SW[1:0] && addr[1:0] != 2'b00);
  // In LOAD_WAIT the held load is still presented and must not be re-accepted.
  assign act = !reset && state == IDLE && mem_valid;
  assign is_ld = act && !mem_store && !bad;
  assign is_st = act && mem_store && !bad;
`ifdef LSU_FORWARD_EN
  assign fwd = is_ld && hit && full_cover;
  assign ld_src = state == LOAD_WAIT ? dcache_dout : fwd_data;
`else
  assign fwd = 1'b0;
  assign ld_src = dcache_dout;
`endif
  assign ld_issue = is_ld && !hit;
  assign drain = !reset && !empty && !ld_issue;
  assign pop = drain && !dcache_busy;
  assign push = is_st && (!full || pop);
  assign lsu_stall = (is_st && full && !pop) || (is_ld && !fwd);
  assign misalign = act && bad;
  assign dcache_re = ld_issue;
  assign dcache_addr = ld_issue ? {addr[ADDR_W-1:2], 2'b00} : drain ? {head_e.waddr[ADDR_W-3:0], 2'b00} : '0;
  assign dcache_we = drain ? head_e.mask : 4'b0000;
  assign dcache_din = drain ? head_e.data : '0;
  assign load_valid = !reset && (state == LOAD_WAIT || fwd);
  assign load_data = load_valid ? load_extend(funct3, addr[1:0], ld_src) : '0;
  assign sb_empty = empty;
  lsu_sb_fifo #(.DEPTH(SB_DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .pop        (pop),
    .din        (new_e),
    .match_waddr(new_e.waddr),
`ifdef LSU_FORWARD_EN
    .match_mask (lanes.mask),
    .full_cover (full_cover),
    .fwd_data   (fwd_data),
`endif
    .hit        (hit),
    .head_e     (head_e),
    .empty      (empty),
    .full       (full)
  );
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_next;
  always_comb begin
    state_next = IDLE;
    state_next = ld_issue && !dcache_busy ? LOAD_WAIT : state_next;
  end
endmodule

// File: doc/lsu_store_buffer_unit.md
# lsu_store_buffer_unit

Parametrised load/store unit for the memory/writeback stage. It replaces direct single-cycle data-cache access with an in-order store buffer of `SB_DEPTH` entries, and arbitrates one data-cache port between loads and buffered stores. Loads may be forwarded from the buffer, and every load and store is checked for alignment. It sits between the stage-3 datapath (ALU address, rs2 data, funct3) and the data cache, and drives a pipeline stall back to the hazard logic.

## Interface
- `SB_DEPTH`, default 4: store-buffer entries; power of two, ≥ 2.
- `ADDR_W`, default 32: byte-address width.

- `clk` input 1: clock.
- `reset` input 1: synchronous, active-high reset.
- `mem_valid` input 1: the stage-3 instruction is a load or a store.
- `mem_store` input 1: 1 = store, 0 = load.
- `funct3` input 3: RV32 load/store funct3.
- `addr` input `ADDR_W`: byte address (ALU output).
- `wdata` input 32: store data (rs2).
- `lsu_stall` output 1: hold the pipeline. While it is 1, all inputs must stay stable.
- `load_valid` output 1: `load_data` is the final load result this cycle.
- `load_data` output 32: aligned, extended load result.
- `misalign` output 1: one-cycle pulse for a misaligned access. The access is dropped.
- `sb_empty` output 1: the buffer holds no stores (used by fence/CSR).
- `dcache_addr` output `ADDR_W`: word-aligned address; bits [1:0] are always 0.
- `dcache_we` output 4: byte write mask.
- `dcache_re` output 1: read enable.
- `dcache_din` output 32: byte-lane-aligned write data.
- `dcache_dout` input 32: read data, valid in the cycle after an accepted read.
- `dcache_busy` input 1: the cache rejects this cycle's request. The request is re-driven next cycle.

## Operation
- **Alignment rules:**
  - SB/LB/LBU are always aligned.
  - SH/LH/LHU require `addr[0]=0`.
  - SW/LW require `addr[1:0]=0`.
  - A violation raises `misalign` for one cycle and produces no access, no enqueue, no stall, and `load_valid=0`.
- **Store:**
  - Enqueue `{addr[ADDR_W-1:2]`, mask, lane-shifted data`}` at the tail in the cycle it is presented.
  - If the buffer is full, `lsu_stall=1` until a slot frees.
  - A pop and an enqueue in the same cycle are legal, including when the buffer is full. The count is unchanged.
- **Drain:**
  - Whenever the port is not taken by a load, the head entry drives `dcache_we`, `dcache_addr` and `dcache_din`.
  - The head pops when `dcache_busy=0`.
- **Port priority:** an issuing load wins over drain.
- **Load dependency check:** compare the load's word address against all valid entries.
  - No match: issue to the cache.
  - Youngest match with a mask covering every requested byte: forward (when the feature is enabled).
  - Any other match: `lsu_stall=1`, no issue, draining continues. Re-evaluate every cycle.
- **FSM states:** IDLE, LOAD_WAIT.
  - IDLE to LOAD_WAIT on an accepted load read (`dcache_re=1`, `dcache_busy=0`).
  - LOAD_WAIT to IDLE unconditionally after one cycle.
- **Extension:**
  - Select the byte or half by `addr[1:0]`.
  - LB/LH sign-extend; LBU/LHU zero-extend; LW passes the word through.
- **Pointers:** head and tail are $clog2(`SB_DEPTH`) bits wide and wrap modulo `SB_DEPTH`. The count is $clog2(`SB_DEPTH`)+1 bits wide.
- **Reset:**
  - Buffer emptied; pending stores are discarded.
  - FSM returns to IDLE.
  - `lsu_stall`, `load_valid`, `misalign`, `dcache_re`, `dcache_we`, `dcache_addr`, `dcache_din` and `load_data` = 0.
  - `sb_empty` = 1.
- **Reset during LOAD_WAIT:** the returning data is ignored.

## Timing
- **Store with the buffer not full:** zero stall cycles. The entry becomes visible to the dependency check in the next cycle.
- **Cache load:**
  - Cycle N: `dcache_re=1`, `lsu_stall=1`.
  - Each cycle with `dcache_busy=1` adds one cycle.
  - Cycle N+1 (state LOAD_WAIT): `load_valid=1`, `load_data` is derived combinationally from `dcache_dout`, `lsu_stall=0`.
- **Forwarded load:** `load_valid=1` and `lsu_stall=0` in the presenting cycle, and no cache access.
- **Drain throughput:** one entry per cycle while the port is free and the cache is not busy.
- **`sb_empty`:** registered from the count. It rises the cycle after the last pop.

## Configuration
- **`LSU_FORWARD_EN` defined:** full-coverage youngest-match loads are forwarded from the buffer, with zero latency.
- **`LSU_FORWARD_EN` undefined:**
  - Any word-address match stalls the load until no matching entry remains.
  - The forwarding mux and per-entry data compare are not built.
  - All other behaviour is identical.

## Structure
- **Package `lsu_pkg`:**
  - funct3 constants (FNC_LB … FNC_SW).
  - `sb_entry_t` struct (word address, mask, data).
  - `lsu_state_t` enum (IDLE, LOAD_WAIT).
  - Mask and lane-shift function `store_lanes(funct3, addr[1:0], wdata)`.
- **Sub-module `lsu_sb_fifo`:**
  - Parametrised FIFO with a parallel match port.
  - Outputs: `hit`, `full_cover`, `fwd_data`, `empty`, `full`.
  - The top level holds the FSM, arbitration, alignment check and extension.

## Test plan
- **SW then forwarded LW:** SW 0xDEADBEEF @0x100, then LW @0x100 with `LSU_FORWARD_EN` defined → `load_valid=1` in the LW's first cycle, `load_data=0xDEADBEEF`, `dcache_re` stays 0.
- **Partial coverage:** SB 0x80 @0x203, then LH @0x202 → stall until the entry drains (`dcache_we=4'b1000`, `dcache_din[31:24]=0x80`). The load then issues and returns `0xFFFF80xx` sign-extended per the cache contents.
- **Full buffer:** 5 back-to-back SW with `SB_DEPTH=4` and `dcache_busy=1` → 5th store sees `lsu_stall=1`. Release busy → one pop, the 5th enqueues that same cycle, count stays 4.
- **Misaligned access:** LW @0x102 → `misalign` pulse, no `dcache_re`, `load_valid=0`. SH @0x301 → `misalign` pulse, `sb_empty` unchanged.
- **Busy during load:** LBU @0x0 with `dcache_busy=1` for 2 cycles and `dcache_dout=0x000000F0` → `lsu_stall=1` for 3 cycles, then `load_data=0x000000F0`, `load_valid=1`.
- **Reset mid-drain:** 3 buffered stores, assert `reset` for 1 cycle → next cycle `sb_empty=1`, `dcache_we=0`, no further writes.
